mat_load_ctrl: RTL and testbench
================================

# mat_load_ctrl

Sequencer for the 3x3 byte-matrix store. Accepts a stream of 8-bit elements from the receive path, writes them row-major into the 9-entry matrix buffer via an explicit write port, holds the matrix valid until the consumer acknowledges it, then zero-clears the buffer before accepting the next matrix. It also discards stalled partial matrices and flags bytes dropped while busy.

## Interface
- TIMEOUT, 50000: idle cycles allowed mid-matrix before the partial matrix is discarded. A value of 0 disables the timeout. The counter is 16 bits wide.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_rx_data  in  8  element byte.
- i_rx_valid  in  1  one-cycle strobe per byte.
- o_rx_ready  out  1  controller can accept a byte this cycle.
- o_wr_en  out  1  buffer write strobe, registered.
- o_wr_addr  out  4  buffer address 0..8, registered.
- o_wr_data  out  8  buffer write data, registered.
- o_mat_valid  out  1  complete matrix present in buffer (level).
- i_mat_ack  in  1  consumer done with matrix.
- o_count  out  4  elements loaded, 0..9.
- o_overrun  out  1  one-cycle pulse: byte dropped.
- o_timeout  out  1  one-cycle pulse: partial matrix discarded.

## Operation
- States: LOAD, COMMIT, HOLD, CLEAR.
- Reset puts the block in LOAD with count=0 and idle=0.
  - Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_mat_valid=0, o_overrun=0, o_timeout=0, o_count=0.
  - o_rx_ready=1, because it is decoded from state.
- o_rx_ready = (state==LOAD), decoded combinationally from registered state only; it never depends on i_rx_valid.
- LOAD, on a cycle with i_rx_valid=1:
  - Next cycle drives o_wr_en=1, o_wr_addr=count, o_wr_data=byte.
  - count increments and idle clears.
  - If this was the 9th byte (count 8→9), go to COMMIT.
- COMMIT lasts exactly one cycle and carries the final write. It always goes to HOLD.
- HOLD: o_mat_valid=1. i_mat_ack=1 sampled at an edge → CLEAR and o_mat_valid=0. i_mat_ack is ignored in every other state.
- CLEAR runs for 9 cycles:
  - o_wr_en=1, o_wr_addr=0..8 ascending, o_wr_data=0.
  - count resets to 0 on entry.
  - After the addr-8 write, go to LOAD.
- Overrun: i_rx_valid=1 in COMMIT, HOLD or CLEAR drops the byte and pulses o_overrun the next cycle. count is unchanged.
- Timeout (TIMEOUT≠0, state LOAD, 1≤count≤8):
  - idle increments on each cycle with no byte.
  - When idle reaches TIMEOUT: pulse o_timeout the next cycle, go to CLEAR. o_count reads 0 from the CLEAR entry.
  - With count=0 the idle counter is held at 0.
- Simultaneous events:
  - Byte and timeout expiry in the same cycle: the byte is accepted, idle clears, no timeout.
  - i_mat_ack and i_rx_valid in the same HOLD cycle: byte dropped (overrun), CLEAR entered.
- Reset asserted mid-matrix or mid-CLEAR: immediate return to reset values. The buffer contents are not cleared by this block.
- o_wr_en is 0 in any cycle not listed above.

## Timing
- Accept at edge E → write signals valid for the cycle after E → buffer stores at E+1.
- 9th byte accepted at edge E0:
  - Addr-8 write is visible in the cycle after E0 (state COMMIT).
  - o_mat_valid rises after E0+1 (HOLD), i.e. after the buffer holds all 9 bytes.
- Best-case load: 9 consecutive strobes, then o_mat_valid 2 cycles after the last strobe edge.
- Ack at edge A: o_mat_valid low after A. Clear writes occupy cycles A+1..A+9; o_rx_ready=1 after edge A+9.
- Back-to-back strobes are legal every cycle in LOAD; there is no bubble between bytes.
- o_overrun and o_timeout are single-cycle pulses, registered, one cycle after the causing edge.

## Test plan
- Reset then 9 strobes of 0x11..0x19 → writes addr 0..8 with data 0x11..0x19, o_count=9, o_mat_valid=1 two cycles after the last strobe, o_rx_ready=0.
- From HOLD, pulse i_mat_ack → o_mat_valid=0 next cycle; 9 writes of data 0x00 to addr 0..8; o_rx_ready returns to 1 ten cycles after the ack edge.
- In HOLD send byte 0xAA → one o_overrun pulse, no o_wr_en, o_count stays 9. Repeat the stimulus in CLEAR → o_overrun, clear sequence unchanged.
- TIMEOUT=8, send 3 bytes then idle → o_timeout pulse at the 8th idle cycle, CLEAR sequence, o_count=0. Next byte 0x55 is written to addr 0.
- TIMEOUT=8, 3 bytes, then a 4th byte exactly on the expiry cycle → no o_timeout, 0x04 written to addr 3, o_count=4.
- Assert i_rst mid-load (count=5) and mid-CLEAR (addr 4) → all outputs at reset values immediately, o_rx_ready=1, next byte goes to addr 0.

Source files
------------

// File: rtl/mat_load_ctrl.sv
// Load sequencer for the 3x3 byte-matrix buffer: streams 9 bytes row-major into
// the buffer, holds the matrix until acknowledged, then zero-clears it.
module mat_load_ctrl #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    output logic       o_wr_en,
    output logic [3:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_mat_valid,
    input  logic       i_mat_ack,
    output logic [3:0] o_count,
    output logic       o_overrun,
    output logic       o_timeout
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 16;
    localparam logic [CW-1:0] LAST_IDX = CW'(8);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] clr_q, clr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          wr_en_q, wr_en_d;
    logic [CW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          mat_valid_q, mat_valid_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= LOAD;
            count_q     <= '0;
            clr_q       <= '0;
            idle_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mat_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            clr_q       <= clr_d;
            idle_q      <= idle_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mat_valid_q <= mat_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        clr_d       = clr_q;
        idle_d      = idle_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mat_valid_d = 1'b0;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            LOAD: begin
                if (i_rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = i_rx_data;
                    count_d   = count_q + CW'(1);
                    idle_d    = '0;
                    if (count_q == LAST_IDX) begin
                        state_d = COMMIT;
                    end
                end else if ((TIMEOUT != 0) && (count_q != '0)) begin
                    // Expiry is the idle cycle that would bring idle up to TIMEOUT
                    if (idle_q == IDLE_MAX - IW'(1)) begin
                        timeout_d = 1'b1;
                        state_d   = CLEAR;
                        count_d   = '0;
                        clr_d     = '0;
                        idle_d    = '0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            COMMIT: begin
                overrun_d   = i_rx_valid;
                mat_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                overrun_d = i_rx_valid;
                if (i_mat_ack) begin
                    state_d = CLEAR;
                    count_d = '0;
                    clr_d   = '0;
                end else begin
                    mat_valid_d = 1'b1;
                end
            end
            CLEAR: begin
                overrun_d = i_rx_valid;
                wr_en_d   = 1'b1;
                wr_addr_d = clr_q;
                wr_data_d = '0;
                clr_d     = clr_q + CW'(1);
                if (clr_q == LAST_IDX) begin
                    state_d = LOAD;
                    idle_d  = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign o_rx_ready  = (state_q == LOAD);
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_mat_valid = mat_valid_q;
    assign o_count     = count_q;
    assign o_overrun   = overrun_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Directed/randomised bench for mat_load_ctrl; keeps its own copy of the matrix
// buffer and predicts every output from the load/hold/clear rules.
module tb_mat_load_ctrl;

    localparam int unsigned TO = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic       i_mat_ack = 1'b0;
    logic       o_rx_ready, o_wr_en, o_mat_valid, o_overrun, o_timeout;
    logic [3:0] o_wr_addr, o_count;
    logic [7:0] o_wr_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem   [9];
    logic [7:0] exp_m [9];

    mat_load_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_mat_valid(o_mat_valid),
        .i_mat_ack  (i_mat_ack),
        .o_count    (o_count),
        .o_overrun  (o_overrun),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // The 9-entry buffer the controller drives
    always @(posedge i_clk) begin
        if (o_wr_en && (o_wr_addr < 4'd9)) mem[o_wr_addr] <= o_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_en"},   32'(o_wr_en), 0);
        chk({tag, "_addr"},    32'(o_wr_addr), 0);
        chk({tag, "_data"},    32'(o_wr_data), 0);
        chk({tag, "_mvalid"},  32'(o_mat_valid), 0);
        chk({tag, "_overrun"}, 32'(o_overrun), 0);
        chk({tag, "_timeout"}, 32'(o_timeout), 0);
        chk({tag, "_count"},   32'(o_count), 0);
        chk({tag, "_ready"},   32'(o_rx_ready), 1);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        exp_m[k]   = b;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        cyc();
        i_rx_valid = 1'b0;
        chk("byte_wr_en", 32'(o_wr_en), 1);
        chk("byte_addr",  32'(o_wr_addr), 32'(k));
        chk("byte_data",  32'(o_wr_data), 32'(b));
        chk("byte_count", 32'(o_count), 32'(k + 1));
        chk("byte_tmo",   32'(o_timeout), 0);
        chk("byte_ready", 32'(o_rx_ready), (k < 8) ? 1 : 0);
    endtask

    task automatic idle(input int n, input int cnt);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("idle_wr_en", 32'(o_wr_en), 0);
            chk("idle_ready", 32'(o_rx_ready), 1);
            chk("idle_tmo",   32'(o_timeout), 0);
            chk("idle_count", 32'(o_count), 32'(cnt));
        end
    endtask

    // TO idle cycles after the last byte: the final one discards the partial matrix
    task automatic expire(input int cnt);
        idle(TO - 1, cnt);
        cyc();
        chk("exp_tmo",   32'(o_timeout), 1);
        chk("exp_count", 32'(o_count), 0);
        chk("exp_ready", 32'(o_rx_ready), 0);
        chk("exp_wr_en", 32'(o_wr_en), 0);
    endtask

    task automatic load_from(input int start, input bit gaps);
        for (int k = start; k < 9; k++) begin
            if (gaps) idle(int'($urandom_range(0, 5)), k);
            send_byte(k, 8'($urandom));
        end
        chk("commit_mvalid", 32'(o_mat_valid), 0);
        cyc();
        chk("hold_mvalid", 32'(o_mat_valid), 1);
        chk("hold_ready",  32'(o_rx_ready), 0);
        chk("hold_count",  32'(o_count), 9);
        chk("hold_wr_en",  32'(o_wr_en), 0);
        for (int k = 0; k < 9; k++) chk("buf_elem", 32'(mem[k]), 32'(exp_m[k]));
    endtask

    // Starts in the first CLEAR cycle; ovr_at < 0 means no stray byte
    task automatic clear_seq(input int ovr_at);
        int nz;
        for (int j = 0; j < 9; j++) begin
            if (j == ovr_at) begin
                i_rx_valid = 1'b1;
                i_rx_data  = 8'hAA;
            end
            cyc();
            i_rx_valid = 1'b0;
            chk("clr_wr_en",  32'(o_wr_en), 1);
            chk("clr_addr",   32'(o_wr_addr), 32'(j));
            chk("clr_data",   32'(o_wr_data), 0);
            chk("clr_count",  32'(o_count), 0);
            chk("clr_mvalid", 32'(o_mat_valid), 0);
            chk("clr_ovr",    32'(o_overrun), (j == ovr_at) ? 1 : 0);
            chk("clr_tmo",    32'(o_timeout), 0);
            chk("clr_ready",  32'(o_rx_ready), (j == 8) ? 1 : 0);
        end
        cyc();
        chk("post_clr_wr_en", 32'(o_wr_en), 0);
        chk("post_clr_ready", 32'(o_rx_ready), 1);
        nz = 0;
        for (int k = 0; k < 9; k++) if (mem[k] != 8'h00) nz++;
        chk("buf_zeroed", 32'(nz), 0);
    endtask

    task automatic ack(input bit with_byte, input int ovr_at);
        i_mat_ack  = 1'b1;
        i_rx_valid = with_byte;
        i_rx_data  = 8'hAA;
        cyc();
        i_mat_ack  = 1'b0;
        i_rx_valid = 1'b0;
        chk("ack_mvalid", 32'(o_mat_valid), 0);
        chk("ack_count",  32'(o_count), 0);
        chk("ack_wr_en",  32'(o_wr_en), 0);
        chk("ack_ready",  32'(o_rx_ready), 0);
        chk("ack_ovr",    32'(o_overrun), 32'(with_byte));
        clear_seq(ovr_at);
    endtask

    initial begin
        for (int k = 0; k < 9; k++) mem[k] = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset("rst");
        i_rst = 1'b0;

        // Empty matrix never times out; ack outside HOLD is ignored
        idle(20, 0);
        i_mat_ack = 1'b1;
        idle(2, 0);
        i_mat_ack = 1'b0;

        for (int k = 0; k < 9; k++) send_byte(k, 8'(8'h11 + k));
        chk("commit_mvalid0", 32'(o_mat_valid), 0);
        cyc();
        chk("hold_mvalid0", 32'(o_mat_valid), 1);
        chk("hold_count0",  32'(o_count), 9);
        chk("hold_ready0",  32'(o_rx_ready), 0);
        for (int k = 0; k < 9; k++) chk("buf0_elem", 32'(mem[k]), 32'(8'h11 + k));

        // Stray byte while holding
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hAA;
        cyc();
        i_rx_valid = 1'b0;
        chk("hold_ovr",       32'(o_overrun), 1);
        chk("hold_ovr_wr_en", 32'(o_wr_en), 0);
        chk("hold_ovr_count", 32'(o_count), 9);
        chk("hold_ovr_mv",    32'(o_mat_valid), 1);
        cyc();
        chk("hold_ovr_pulse", 32'(o_overrun), 0);
        chk("hold_mv_stays",  32'(o_mat_valid), 1);

        ack(1'b0, 4);

        load_from(0, 1'b1);
        ack(1'b1, -1);
        load_from(0, 1'b1);
        ack(1'b0, -1);

        // Partial matrix discarded after TO idle cycles
        for (int k = 0; k < 3; k++) send_byte(k, 8'($urandom));
        expire(3);
        clear_seq(-1);
        send_byte(0, 8'h55);
        load_from(1, 1'b0);
        chk("buf_first_55", 32'(mem[0]), 32'h55);
        ack(1'b0, -1);

        // Byte on the expiry cycle wins and restarts the idle window
        for (int k = 0; k < 3; k++) send_byte(k, 8'(k + 1));
        idle(TO - 1, 3);
        send_byte(3, 8'h04);
        expire(4);
        clear_seq(-1);

        // Asynchronous reset mid-load
        for (int k = 0; k < 5; k++) send_byte(k, 8'($urandom));
        #2 i_rst = 1'b1;
        #1 chk_reset("rst_load");
        cyc();
        i_rst = 1'b0;
        send_byte(0, 8'($urandom));
        load_from(1, 1'b0);

        // Asynchronous reset mid-clear, right after the addr-4 write appears
        i_mat_ack = 1'b1;
        cyc();
        i_mat_ack = 1'b0;
        for (int j = 0; j < 5; j++) cyc();
        chk("pre_rst_addr", 32'(o_wr_addr), 4);
        #2 i_rst = 1'b1;
        #1 chk_reset("rst_clear");
        cyc();
        i_rst = 1'b0;
        send_byte(0, 8'h3C);
        load_from(1, 1'b1);
        ack(1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
